// File: rtl/qmac_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : qmac_seq_if
// Description : Signal bundle around the qmac sequencer. It carries the
//               operand-pair input stream, the registered operand/clear
//               drive into the downstream qmac accumulator, the accumulator
//               read-back, and the requantized result stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N  : operand / result word width (signed two's complement)
//   CW : width of the beat counter reported with each result
// Signals (direction as seen by the sequencer, modport slave):
//   in_valid     in   operand pair offered
//   in_ready     out  sequencer accepts the pair this cycle
//   in_x, in_w   in   activation / weight, Q-format
//   in_last      in   final beat of the vector
//   mac_a, mac_b out  registered operands into the qmac
//   mac_clr      out  registered clear, wired to the qmac reset
//   mac_result   in   qmac accumulator (2N bits, 2Q fractional bits)
//   mac_overflow in   qmac adder overflow for the current addition
//   out_valid    out  result available
//   out_ready    in   result consumer accepts
//   out_data     out  requantized, clamped dot product
//   out_sat      out  result was clamped
//   out_ovf      out  an accumulator overflow occurred in this vector
//   out_trunc    out  vector was cut at the maximum length
//   out_cnt      out  beats accumulated in this vector
// The master modport is the mirror image, for the environment side.
// ============================================================================
interface qmac_seq_if #(
    parameter int N  = 8,
    parameter int CW = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in_x;
    logic [N-1:0]        in_w;
    logic                in_last;

    logic [N-1:0]        mac_a;
    logic [N-1:0]        mac_b;
    logic                mac_clr;
    logic [2*N-1:0]      mac_result;
    logic                mac_overflow;

    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_data;
    logic                out_sat;
    logic                out_ovf;
    logic                out_trunc;
    logic [CW-1:0]       out_cnt;

    modport slave (
        input  in_valid, in_x, in_w, in_last,
        input  mac_result, mac_overflow,
        input  out_ready,
        output in_ready,
        output mac_a, mac_b, mac_clr,
        output out_valid, out_data, out_sat, out_ovf, out_trunc, out_cnt
    );

    modport master (
        output in_valid, in_x, in_w, in_last,
        output mac_result, mac_overflow,
        output out_ready,
        input  in_ready,
        input  mac_a, mac_b, mac_clr,
        input  out_valid, out_data, out_sat, out_ovf, out_trunc, out_cnt
    );
endinterface
`default_nettype wire

// File: rtl/qmac_seq.sv
`default_nettype none
// ============================================================================
// Module      : qmac_seq
// Description : Sequencer for an external multiply-accumulate unit (qmac).
//               Accepts a vector of Q-format operand pairs, streams them into
//               the qmac one pair per accepted beat (zeros on idle cycles),
//               then requantizes the 2N-bit accumulator back to N bits with
//               round-half-up and saturation, and presents the result with
//               status flags on a valid/ready output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N   : operand / output width, signed
//   Q   : fractional bits per operand (accumulator carries 2Q), Q >= 1
//   LEN : maximum beats per vector; longer streams are cut and the rest
//         starts the next vector
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; aborts any vector in flight
//   bus   : qmac_seq_if slave modport (input stream, qmac drive/read-back,
//           result stream)
// ============================================================================
module qmac_seq #(
    parameter int N   = 8,
    parameter int Q   = 5,
    parameter int LEN = 16
) (
    input  wire         clk,
    input  wire         reset,
    qmac_seq_if.slave   bus
);

    localparam int CW = $clog2(LEN + 1);
    // Requantization is done one bit wider than the accumulator so the
    // rounding increment can never wrap.
    localparam int W  = 2 * N + 1;

    localparam logic [CW-1:0]       c_CNT_LAST = CW'(LEN - 1);
    localparam logic signed [W-1:0] c_RND      = W'(1) << (Q - 1);
    localparam logic signed [W-1:0] c_MAX      = (W'(1) << (N - 1)) - W'(1);
    localparam logic signed [W-1:0] c_MIN      = ~c_MAX;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_CAPT = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               mac_clr_q, mac_clr_d;
    logic [N-1:0]       mac_a_q, mac_a_d;
    logic [N-1:0]       mac_b_q, mac_b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               trunc_q, trunc_d;
    logic [N-1:0]       out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_trunc_q, out_trunc_d;
    logic [CW-1:0]      out_cnt_q, out_cnt_d;

    // ------------------------------------------------------------------
    // Requantization of the accumulator: round half up, then clamp.
    // A wrapped accumulator is used as-is; out_ovf tells the consumer.
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_ext;
    logic signed [W-1:0] w_rnd;
    logic signed [W-1:0] w_shr;
    logic                w_hi;
    logic                w_lo;
    logic [N-1:0]        w_qout;

    always_comb begin
        w_ext = {bus.mac_result[2*N-1], bus.mac_result};
        w_rnd = w_ext + c_RND;
        w_shr = w_rnd >>> Q;
        w_hi  = (w_shr > c_MAX);
        w_lo  = (w_shr < c_MIN);
        if (w_hi) begin
            w_qout = c_MAX[N-1:0];
        end else if (w_lo) begin
            w_qout = c_MIN[N-1:0];
        end else begin
            w_qout = w_shr[N-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        // Operands default to zero so any cycle without an accepted beat
        // adds nothing to the qmac accumulator.
        mac_a_d     = '0;
        mac_b_d     = '0;
        mac_clr_d   = 1'b0;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        trunc_d     = trunc_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;
        out_cnt_d   = out_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mac_clr_d = 1'b1;
                    state_d   = S_CLR;
                end
            end

            // mac_clr is high for this whole cycle, so the qmac clears on
            // the edge that leaves CLR.
            S_CLR: begin
                cnt_d   = '0;
                ovf_d   = 1'b0;
                trunc_d = 1'b0;
                state_d = S_RUN;
            end

            S_RUN: begin
                ovf_d = ovf_q | bus.mac_overflow;
                if (bus.in_valid) begin
                    mac_a_d = bus.in_x;
                    mac_b_d = bus.in_w;
                    cnt_d   = cnt_q + CW'(1);
                    if (bus.in_last) begin
                        state_d = S_WAIT;
                    end else if (cnt_q == c_CNT_LAST) begin
                        // Length cap reached without in_last: the stream
                        // continues into a fresh vector.
                        trunc_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end

            // Final pair is on mac_a/mac_b during this cycle; its addition
            // (and possible overflow) lands on the edge leaving WAIT.
            S_WAIT: begin
                ovf_d   = ovf_q | bus.mac_overflow;
                state_d = S_CAPT;
            end

            S_CAPT: begin
                out_data_d  = w_qout;
                out_sat_d   = w_hi | w_lo;
                out_ovf_d   = ovf_q;
                out_trunc_d = trunc_q;
                out_cnt_d   = cnt_q;
                state_d     = S_OUT;
            end

            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mac_clr_q   <= 1'b1;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            trunc_q     <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mac_clr_q   <= mac_clr_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            trunc_q     <= trunc_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_trunc = out_trunc_q;
    assign bus.out_cnt   = out_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_qmac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_qmac_seq
// Description : Self-checking bench for qmac_seq. Two instances share clock
//               and reset: A with LEN=16, B with LEN=4. Each has a
//               behavioural qmac (2N-bit accumulator, combinational adder
//               overflow) and an expected-result queue filled when a vector
//               is driven and drained by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qmac_seq;

    localparam int N     = 8;
    localparam int Q     = 5;
    localparam int LEN_A = 16;
    localparam int LEN_B = 4;
    localparam int CW_A  = $clog2(LEN_A + 1);
    localparam int CW_B  = $clog2(LEN_B + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qmac_seq_if #(.N(N), .CW(CW_A)) a ();
    qmac_seq_if #(.N(N), .CW(CW_B)) b ();

    qmac_seq #(.N(N), .Q(Q), .LEN(LEN_A)) u_dut_a (.clk(clk), .reset(rst), .bus(a));
    qmac_seq #(.N(N), .Q(Q), .LEN(LEN_B)) u_dut_b (.clk(clk), .reset(rst), .bus(b));

    // ---------------- downstream qmac models ----------------
    logic signed [2*N-1:0] acc_a, prod_a, sum_a;
    logic signed [2*N-1:0] acc_b, prod_b, sum_b;

    always_comb begin
        prod_a         = (2*N)'($signed(a.mac_a)) * (2*N)'($signed(a.mac_b));
        sum_a          = acc_a + prod_a;
        a.mac_result   = acc_a;
        a.mac_overflow = (acc_a[2*N-1] == prod_a[2*N-1]) && (sum_a[2*N-1] != acc_a[2*N-1]);
    end
    always @(posedge clk) acc_a <= a.mac_clr ? '0 : sum_a;

    always_comb begin
        prod_b         = (2*N)'($signed(b.mac_a)) * (2*N)'($signed(b.mac_b));
        sum_b          = acc_b + prod_b;
        b.mac_result   = acc_b;
        b.mac_overflow = (acc_b[2*N-1] == prod_b[2*N-1]) && (sum_b[2*N-1] != acc_b[2*N-1]);
    end
    always @(posedge clk) acc_b <= b.mac_clr ? '0 : sum_b;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] data;
        logic       sat;
        logic       ovf;
        logic       trunc;
        logic [7:0] cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic [7:0] d, input logic s, input logic o,
                                input logic t, input logic [7:0] c);
        exp_t e;
        e.data  = d;
        e.sat   = s;
        e.ovf   = o;
        e.trunc = t;
        e.cnt   = c;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitors: pop one expectation per result handshake.
    always @(negedge clk) begin
        if (a.out_valid === 1'b1 && a.out_ready === 1'b1) begin
            check("A_out_expected", {31'd0, qa.size() != 0}, 32'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                check("A_out_data",  a.out_data,  ea.data);
                check("A_out_sat",   a.out_sat,   ea.sat);
                check("A_out_ovf",   a.out_ovf,   ea.ovf);
                check("A_out_trunc", a.out_trunc, ea.trunc);
                check("A_out_cnt",   a.out_cnt,   ea.cnt);
            end
        end
        if (b.out_valid === 1'b1 && b.out_ready === 1'b1) begin
            check("B_out_expected", {31'd0, qb.size() != 0}, 32'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                check("B_out_data",  b.out_data,  eb.data);
                check("B_out_sat",   b.out_sat,   eb.sat);
                check("B_out_ovf",   b.out_ovf,   eb.ovf);
                check("B_out_trunc", b.out_trunc, eb.trunc);
                check("B_out_cnt",   b.out_cnt,   eb.cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit sel, input logic v, input logic [7:0] x,
                         input logic [7:0] w, input logic l);
        if (!sel) begin
            a.in_valid = v; a.in_x = x; a.in_w = w; a.in_last = l;
        end else begin
            b.in_valid = v; b.in_x = x; b.in_w = w; b.in_last = l;
        end
    endtask

    // Offer one beat, wait (bounded) for acceptance, return #1 after the
    // accepting edge with in_valid dropped.
    task automatic send(input bit sel, input logic [7:0] x, input logic [7:0] w,
                        input logic l);
        int k;
        bit rdy;
        k   = 0;
        rdy = 1'b0;
        drive(sel, 1'b1, x, w, l);
        while (k < 40) begin
            @(negedge clk);
            rdy = sel ? (b.in_ready === 1'b1) : (a.in_ready === 1'b1);
            if (rdy) break;
            k++;
        end
        check(sel ? "B_accept" : "A_accept", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic wait_drain(input bit sel);
        int k;
        k = 0;
        while (k < 100 && (sel ? qb.size() : qa.size()) != 0) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(sel ? "B_drained" : "A_drained", sel ? qb.size() : qa.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        a.out_ready = 1'b1;
        b.out_ready = 1'b1;

        // Reset held for two edges
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_A_in_ready",  a.in_ready,  0);
        check("rst_A_out_valid", a.out_valid, 0);
        check("rst_A_out_data",  a.out_data,  0);
        check("rst_A_flags",     {a.out_sat, a.out_ovf, a.out_trunc}, 0);
        check("rst_A_out_cnt",   a.out_cnt,   0);
        check("rst_A_mac_ab",    {a.mac_a, a.mac_b}, 0);
        check("rst_A_mac_clr",   a.mac_clr,   1);
        check("rst_B_out_valid", b.out_valid, 0);
        check("rst_B_mac_clr",   b.mac_clr,   1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_A_mac_clr",  a.mac_clr,  0);
        check("rel_A_in_ready", a.in_ready, 0);
        check("rel_B_mac_clr",  b.mac_clr,  0);

        // Two beats: 1.0*1.0 + 1.0*(-1.0) = 0, with latency checks
        qa.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 8'd2));
        drive(1'b0, 1'b1, 8'd32, 8'd32, 1'b0);
        @(posedge clk); #1;
        check("lat_clr_in_ready", a.in_ready, 0);
        check("lat_clr_mac_clr",  a.mac_clr,  1);
        @(posedge clk); #1;
        check("lat_run_in_ready", a.in_ready, 1);
        check("lat_run_mac_clr",  a.mac_clr,  0);
        send(1'b0, 8'd32, 8'd32, 1'b0);
        check("beat1_mac_a", a.mac_a, 8'd32);
        check("beat1_mac_b", a.mac_b, 8'd32);
        send(1'b0, 8'd32, 8'hE0, 1'b1);
        check("wait_in_ready",  a.in_ready,  0);
        check("acc0_out_valid", a.out_valid, 0);
        check("beat2_mac_b",    a.mac_b,     8'hE0);
        @(posedge clk); #1;
        check("acc1_out_valid", a.out_valid, 0);
        check("capt_mac_a",     a.mac_a,     0);
        @(posedge clk); #1;
        check("acc2_out_valid", a.out_valid, 1);

        // Single-beat vectors
        qa.push_back(mk(8'd64,  1'b0, 1'b0, 1'b0, 8'd1));
        send(1'b0, 8'd32, 8'd64, 1'b1);
        qa.push_back(mk(8'd1,   1'b0, 1'b0, 1'b0, 8'd1));
        send(1'b0, 8'd1, 8'd16, 1'b1);
        qa.push_back(mk(8'd0,   1'b0, 1'b0, 1'b0, 8'd1));
        send(1'b0, 8'd1, 8'd15, 1'b1);
        qa.push_back(mk(8'd127, 1'b1, 1'b0, 1'b0, 8'd1));
        send(1'b0, 8'd127, 8'd127, 1'b1);

        // Accumulator overflow: 3 * 16129 wraps to -17149 -> clamps low
        qa.push_back(mk(8'h80, 1'b1, 1'b1, 1'b0, 8'd3));
        send(1'b0, 8'd127, 8'd127, 1'b0);
        send(1'b0, 8'd127, 8'd127, 1'b0);
        send(1'b0, 8'd127, 8'd127, 1'b1);

        // Same vector without and with a 3-cycle bubble: -1821 -> -57
        qa.push_back(mk(8'hC7, 1'b0, 1'b0, 1'b0, 8'd3));
        send(1'b0, 8'd10,  8'd20,  1'b0);
        send(1'b0, 8'hFD,  8'd7,   1'b0);
        send(1'b0, 8'd50,  8'hD8,  1'b1);
        qa.push_back(mk(8'hC7, 1'b0, 1'b0, 1'b0, 8'd3));
        send(1'b0, 8'd10,  8'd20,  1'b0);
        @(posedge clk); #1;
        check("bubble_mac_a", a.mac_a, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(1'b0, 8'hFD,  8'd7,   1'b0);
        send(1'b0, 8'd50,  8'hD8,  1'b1);
        wait_drain(1'b0);

        // Output backpressure with in_valid asserted and ignored
        a.out_ready = 1'b0;
        qa.push_back(mk(8'd64, 1'b0, 1'b0, 1'b0, 8'd1));
        send(1'b0, 8'd32, 8'd64, 1'b1);
        k = 0;
        while (k < 10 && a.out_valid !== 1'b1) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_valid_rise", a.out_valid, 1);
        drive(1'b0, 1'b1, 8'd5, 8'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", a.out_valid, 1);
            check("bp_out_data",  a.out_data,  8'd64);
            check("bp_out_cnt",   a.out_cnt,   1);
            check("bp_in_ready",  a.in_ready,  0);
            check("bp_mac_a",     a.mac_a,     0);
        end
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        a.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_out_valid", a.out_valid, 0);
        @(posedge clk); #1;
        check("bp_idle_in_ready", a.in_ready, 0);
        check("bp_idle_mac_clr",  a.mac_clr,  0);
        wait_drain(1'b0);

        // LEN=4 instance: 5-beat stream, last on beat 5
        qb.push_back(mk(8'd32, 1'b0, 1'b0, 1'b1, 8'd4));
        qb.push_back(mk(8'd8,  1'b0, 1'b0, 1'b0, 8'd1));
        send(1'b1, 8'd8, 8'd32, 1'b0);
        send(1'b1, 8'd8, 8'd32, 1'b0);
        send(1'b1, 8'd8, 8'd32, 1'b0);
        send(1'b1, 8'd8, 8'd32, 1'b0);
        check("B_forced_exit_in_ready", b.in_ready, 0);
        send(1'b1, 8'd8, 8'd32, 1'b1);
        wait_drain(1'b1);

        // Reset in the middle of a vector: no result, then clean restart
        send(1'b1, 8'd8, 8'd32, 1'b0);
        send(1'b1, 8'd8, 8'd32, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("B_midrst_out_valid", b.out_valid, 0);
        check("B_midrst_mac_clr",   b.mac_clr,   1);
        check("B_midrst_in_ready",  b.in_ready,  0);
        check("B_midrst_out_cnt",   b.out_cnt,   0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("B_postrst_out_valid", b.out_valid, 0);
        end
        qb.push_back(mk(8'd8, 1'b0, 1'b0, 1'b0, 8'd1));
        send(1'b1, 8'd8, 8'd32, 1'b1);
        wait_drain(1'b1);
        wait_drain(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
